// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   - state_t      : FSM state encoding (IDLE, CALC)
//   - BOOTH_W      : operand width (16)
//   - PROD_W       : product width (32)
//   - CNT_W        : step counter width (holds 0..16)
//   - CODE_ADD/SUB : Booth codes {Q[0], q_1} that trigger +M / -M
//   - low_bits_equal() : helper for the optional early-termination logic
// -----------------------------------------------------------------------------
package booth_pkg;

  localparam int BOOTH_W = 16;
  localparam int PROD_W  = 32;
  localparam int CNT_W   = 5;

  localparam logic [1:0] CODE_ADD = 2'b01;
  localparam logic [1:0] CODE_SUB = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // True when bits[n-1:0] are all zeros or all ones (n in 1..16).
  function automatic logic low_bits_equal(input logic [BOOTH_W-1:0] bits,
                                          input logic [CNT_W-1:0]   n);
    logic [BOOTH_W:0]   mask_wide;
    logic [BOOTH_W-1:0] mask;
    mask_wide = (17'd1 << n) - 17'd1;
    mask      = mask_wide[BOOTH_W-1:0];
    return ((bits & mask) == '0) || ((bits | ~mask) == '1);
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// -----------------------------------------------------------------------------
// booth_addsub
// Arithmetic half of one Booth step: selects +M or ~M through mux2_1_16b,
// sign-extends the selected value to 17 bits and adds it to A with a carry-in
// equal to the select (so ~M + 1 = -M). For codes 00/11 A passes through.
// The arithmetic right shift is done by the caller.
// Ports:
//   i_a    : 17-bit partial accumulator A
//   i_m    : 16-bit signed multiplicand M
//   i_code : Booth code {Q[0], q_1}
//   o_a    : A after the add/subtract (before the shift)
// -----------------------------------------------------------------------------
module booth_addsub
  import booth_pkg::*;
(
  input  logic [BOOTH_W:0]   i_a,
  input  logic [BOOTH_W-1:0] i_m,
  input  logic [1:0]         i_code,
  output logic [BOOTH_W:0]   o_a
);

  logic               w_sel;
  logic [BOOTH_W-1:0] w_m_n;
  logic [BOOTH_W-1:0] w_opnd16;
  logic [BOOTH_W:0]   w_opnd17;
  logic [BOOTH_W:0]   w_sum;

  assign w_sel = (i_code == CODE_SUB);
  assign w_m_n = ~i_m;

  mux2_1_16b u_opnd_mux (
    .i_sel (w_sel),
    .i_in1 (i_m),
    .i_in2 (w_m_n),
    .o_y   (w_opnd16)
  );

  // Bit 16 is the sign of the selected 16-bit value, so -(-32768) = +32768
  // is representable in the 17-bit A.
  assign w_opnd17 = {w_opnd16[BOOTH_W-1], w_opnd16};
  assign w_sum    = i_a + w_opnd17 + {{BOOTH_W{1'b0}}, w_sel};

  assign o_a = ((i_code == CODE_ADD) || (i_code == CODE_SUB)) ? w_sum : i_a;

endmodule

// File: rtl/mux2_1_16b.sv
// -----------------------------------------------------------------------------
// mux2_1_16b
// 16-bit 2:1 operand-select mux feeding the accumulator adder.
// Ports:
//   i_sel  : 0 selects i_in1, 1 selects i_in2
//   i_in1  : first data input
//   i_in2  : second data input
//   o_y    : selected value
// -----------------------------------------------------------------------------
module mux2_1_16b (
  input  logic        i_sel,
  input  logic [15:0] i_in1,
  input  logic [15:0] i_in2,
  output logic [15:0] o_y
);

  assign o_y = i_sel ? i_in2 : i_in1;

endmodule

// File: rtl/booth_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_seq_mult
// Sequential radix-2 Booth multiplier, 16x16 signed -> 32 signed, for the FIR
// tap MAC. One Booth step per clock in CALC; 16 steps per multiply.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   start        : multiply request, sampled only in IDLE
//   multiplicand : signed M (coefficient), captured on accept
//   multiplier   : signed Q (sample), captured on accept
//   busy         : high while in CALC
//   done         : one-cycle pulse when product is updated
//   product      : signed M*Q, held until the next completion
// Build option:
//   BOOTH_SKIP_EN : early termination. When the multiplier bits not yet
//                   consumed are all equal, the rest of the steps are pure
//                   shifts; the whole remaining shift is done in one cycle
//                   and the multiply completes. Products are identical.
// -----------------------------------------------------------------------------
module booth_seq_mult
  import booth_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOOTH_W-1:0] multiplicand,
  input  logic [BOOTH_W-1:0] multiplier,
  output logic               busy,
  output logic               done,
  output logic [PROD_W-1:0]  product
);

  state_t             r_state;
  logic [BOOTH_W:0]   r_a;
  logic [BOOTH_W-1:0] r_q;
  logic               r_q1;
  logic [BOOTH_W-1:0] r_m;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_code;
  logic [BOOTH_W:0]   w_a_arith;
  logic [BOOTH_W:0]   w_a_step;
  logic [BOOTH_W-1:0] w_q_step;
  logic               w_skip;
  logic [BOOTH_W:0]   w_fin_a;
  logic [BOOTH_W-1:0] w_fin_q;
  logic               w_last;

  assign w_code = {r_q[0], r_q1};

  booth_addsub u_addsub (
    .i_a    (r_a),
    .i_m    (r_m),
    .i_code (w_code),
    .o_a    (w_a_arith)
  );

  // Arithmetic right shift of {A, Q, q_1} by one, replicating A[16].
  assign w_a_step = {w_a_arith[BOOTH_W], w_a_arith[BOOTH_W:1]};
  assign w_q_step = {w_a_arith[0], r_q[BOOTH_W-1:1]};

`ifdef BOOTH_SKIP_EN
  // r_q[r_cnt-1:0] are the multiplier bits not yet consumed. The current pair
  // {Q[0], q_1} may still need an add/sub, so that is always applied; if the
  // unconsumed bits are all equal, every later pair is 00 or 11 and the
  // remaining r_cnt shifts collapse into one barrel shift of {A, Q}.
  logic signed [2*BOOTH_W:0] w_pair;
  logic signed [2*BOOTH_W:0] w_pair_sh;

  assign w_pair    = {w_a_arith, r_q};
  assign w_pair_sh = w_pair >>> r_cnt;
  assign w_skip    = (r_state == CALC) && low_bits_equal(r_q, r_cnt);
  assign w_fin_a   = w_skip ? w_pair_sh[2*BOOTH_W:BOOTH_W] : w_a_step;
  assign w_fin_q   = w_skip ? w_pair_sh[BOOTH_W-1:0]       : w_q_step;
`else
  assign w_skip  = 1'b0;
  assign w_fin_a = w_a_step;
  assign w_fin_q = w_q_step;
`endif

  // The step taken while r_cnt==1 is the 16th and final one.
  assign w_last = (r_cnt == CNT_W'(1)) || w_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_q1    <= 1'b0;
            r_m     <= multiplicand;
            r_cnt   <= CNT_W'(BOOTH_W);
            r_state <= CALC;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          // After any number of pure shifts the last bit shifted out of Q
          // equals the current Q[0], so q_1 follows Q[0] in both paths.
          r_q1 <= r_q[0];
          if (w_last) begin
            r_a     <= w_fin_a;
            r_q     <= w_fin_q;
            r_cnt   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {w_fin_a[BOOTH_W-1:0], w_fin_q};
          end else begin
            r_a   <= w_a_step;
            r_q   <= w_q_step;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mult
// Self-checking bench for booth_seq_mult. Cycle k after an accept edge is
// observed on the falling edge before rising edge accept+k, so done is seen
// at k == latency and busy for k = 1 .. latency-1. Expected products come
// from integer multiplication; expected latency from the length of the sign
// run at the top of the multiplier when BOOTH_SKIP_EN is defined.
// -----------------------------------------------------------------------------
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_seq_mult dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_product(input logic [15:0] m, input logic [15:0] q);
    int a;
    int b;
    a = int'($signed(m));
    b = int'($signed(q));
    return 32'(a * b);
  endfunction

  function automatic int ref_latency(input logic [15:0] q);
`ifdef BOOTH_SKIP_EN
    int  run;
    bit  same;
    run  = 1;
    same = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      if (same && (q[i] == q[15])) run++;
      else same = 1'b0;
    end
    return 18 - run;
`else
    return 17;
`endif
  endfunction

  // Entered at a falling edge with start=1 and operands already driven.
  // Returns at the falling edge of the done cycle (or after the time budget).
  task automatic mult(input logic [15:0] m, input logic [15:0] q, input int poke, input string tag);
    logic [31:0] exp_p;
    int lat;
    int busy_cnt;
    int done_cyc;
    int overlap;
    exp_p    = ref_product(m, q);
    lat      = ref_latency(q);
    busy_cnt = 0;
    done_cyc = 0;
    overlap  = 0;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    for (int k = 1; (k <= 40) && (done_cyc == 0); k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) done_cyc = k;
      if ((poke != 0) && (k == poke)) begin
        start        = 1'b1;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
      end
      if ((poke != 0) && (k == poke + 1)) start = 1'b0;
    end
    check({tag, "_latency"}, 32'(done_cyc), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_product"}, product, exp_p);
    $display("txn %s: M=%h Q=%h product=%h latency=%0d", tag, m, q, product, done_cyc);
  endtask

  task automatic go(input logic [15:0] m, input logic [15:0] q, input int poke, input string tag);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    mult(m, q, poke, tag);
  endtask

  task automatic idle(input int n, input string tag, input logic [31:0] exp_p);
    int extra;
    extra = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
    check({tag, "_product_hold"}, product, exp_p);
  endtask

  initial begin
    logic [15:0] rm;
    logic [15:0] rq;
    logic [15:0] r;

    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values from the test plan.
    go(16'd3, 16'hFFFB, 0, "basic");
    check("basic_const", product, 32'hFFFFFFF1);
    idle(2, "basic", 32'hFFFFFFF1);
    go(16'h8000, 16'h8000, 0, "min_x_min");
    check("min_x_min_const", product, 32'h40000000);
    idle(1, "min_x_min", 32'h40000000);
    go(16'h7FFF, 16'h8000, 0, "max_x_min");
    check("max_x_min_const", product, 32'hC0008000);
    idle(1, "max_x_min", 32'hC0008000);
    go(16'h7FFF, 16'h7FFF, 0, "max_x_max");
    check("max_x_max_const", product, 32'h3FFF0001);
    idle(1, "max_x_max", 32'h3FFF0001);

    // Start raised at accept+5 while busy must be ignored.
    go(16'h1234, 16'h80AB, 5, "start_while_busy");
    idle(25, "start_while_busy", ref_product(16'h1234, 16'h80AB));

    // Back-to-back: second start raised in the done cycle.
    go(16'h0101, 16'hF00F, 0, "b2b_first");
    go(16'd2, 16'd2, 0, "b2b_second");
    check("b2b_second_const", product, 32'h00000004);
    idle(2, "b2b", 32'h00000004);

    // Asynchronous reset at accept+8.
    multiplicand = 16'h0777;
    multiplier   = 16'h8123;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", product, 32'd0);
    $display("txn abort: reset asserted at accept+8, busy=%0d done=%0d product=%h", busy, done, product);
    @(negedge clk);
    rst = 1'b0;
    idle(25, "abort", 32'd0);
    go(16'hFFF0, 16'h0033, 0, "after_abort");
    idle(1, "after_abort", ref_product(16'hFFF0, 16'h0033));

    // Early-termination cases (same products, 17-cycle latency without the option).
    go(16'h5A5A, 16'h0000, 0, "q_zero");
    check("q_zero_const", product, 32'h00000000);
    idle(1, "q_zero", 32'h00000000);
    go(16'hFFF9, 16'h0001, 0, "q_one");
    check("q_one_const", product, 32'hFFFFFFF9);
    idle(1, "q_one", 32'hFFFFFFF9);

    // Randomized operands; some multipliers get long sign runs.
    for (int i = 0; i < 24; i++) begin
      rm = 16'($urandom);
      r  = 16'($urandom);
      if (i % 3 == 0)      rq = {{8{r[7]}}, r[7:0]};
      else if (i % 3 == 1) rq = {{12{r[3]}}, r[3:0]};
      else                 rq = r;
      go(rm, rq, 0, $sformatf("rand%0d", i));
      idle(1, $sformatf("rand%0d", i), ref_product(rm, rq));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
